// File: rtl/thrust_input_if.sv
// thrust_input_if: player thrust controls in, conditioned thrust lever value out
//   dpad_mode      - 1 selects the D-pad ramp, 0 the analog stick
//   joy_up         - D-pad up, lowers thrust
//   joy_down       - D-pad down, raises thrust
//   analog_y       - signed stick Y, -128 is full up
//   thrust         - registered 8-bit lever value
//   thrust_changed - one-cycle pulse on a new thrust value
//   at_limit       - thrust sits at 0 or the upper clamp
interface thrust_input_if;
  logic       dpad_mode;
  logic       joy_up;
  logic       joy_down;
  logic [7:0] analog_y;
  logic [7:0] thrust;
  logic       thrust_changed;
  logic       at_limit;
  modport master(
    output dpad_mode, joy_up, joy_down, analog_y,
    input  thrust, thrust_changed, at_limit
  );
  modport slave(
    input  dpad_mode, joy_up, joy_down, analog_y,
    output thrust, thrust_changed, at_limit
  );
endinterface

// File: rtl/thrust_input.sv
// thrust_input: conditions stick or D-pad input into the core's 8-bit THRUST lever value
//   clk_sys - system clock
//   reset   - asynchronous active-high reset
//   bus     - thrust_input_if.slave: controls in, thrust/thrust_changed/at_limit out
module thrust_input #(
  parameter int TICK_DIV   = 196850,
  parameter int MAX_THRUST = 254
) (
  input logic           clk_sys,
  input logic           reset,
  thrust_input_if.slave bus
);
  localparam int            CW   = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [7:0]    MAX  = 8'(MAX_THRUST);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    acc_q, acc_d, thrust_q, thrust_d, ana_c;
  logic [8:0]    ana;
  logic          mode_q, changed_q, changed_d, limit_q, limit_d;
  logic          tick, rise, inc, dec;
  always_comb begin
    // 127 - y in 9 bits; result is always 0..255 so bit 8 only matters for the clamp
    ana       = 9'd127 - {bus.analog_y[7], bus.analog_y};
    ana_c     = ana > {1'b0, MAX} ? MAX : ana[7:0];
    tick      = cnt_q == LAST;
    rise      = bus.dpad_mode & ~mode_q;
    inc       = tick & bus.joy_down & ~bus.joy_up & (acc_q < MAX);
    dec       = tick & bus.joy_up & ~bus.joy_down & (acc_q != 8'd0);
    // a mode switch restarts the step period so the first step is a full period away
    cnt_d     = (rise | tick) ? '0 : cnt_q + 1'b1;
    // bumpless transfer: the ramp resumes from where the stick was
    acc_d     = rise ? ana_c : inc ? acc_q + 8'd1 : dec ? acc_q - 8'd1 : acc_q;
    // on the switch cycle acc_q is stale, so keep following the stick one more cycle
    thrust_d  = (bus.dpad_mode & ~rise) ? acc_q : ana_c;
    changed_d = thrust_d != thrust_q;
    limit_d   = thrust_d == 8'd0 || thrust_d == MAX;
  end
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      mode_q    <= 1'b0;
      thrust_q  <= '0;
      changed_q <= 1'b0;
      limit_q   <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mode_q    <= bus.dpad_mode;
      thrust_q  <= thrust_d;
      changed_q <= changed_d;
      limit_q   <= limit_d;
    end
  end
  assign bus.thrust         = thrust_q;
  assign bus.thrust_changed = changed_q;
  assign bus.at_limit       = limit_q;
endmodule

// File: tb/tb_thrust_input.sv
// tb_thrust_input: scoreboard bench for thrust_input with a 4-cycle ramp step
module tb_thrust_input;
  typedef struct packed {
    logic [7:0] t;
    logic       c;
    logic       l;
  } vec_t;
  logic clk_sys;
  logic reset;
  vec_t sb[$];
  vec_t e;
  int   vectors;
  int   miscompares;
  thrust_input_if bus();
  thrust_input #(.TICK_DIV(4), .MAX_THRUST(254)) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .bus(bus.slave)
  );
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
  endtask
  task automatic test_reset();
    bus.dpad_mode = 1'b0;
    bus.joy_up    = 1'b0;
    bus.joy_down  = 1'b0;
    bus.analog_y  = 8'h00;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    sb.push_back('{8'd0, 1'b0, 1'b1});
    e = sb.pop_front();
    vectors++;
    if ({bus.thrust, bus.thrust_changed, bus.at_limit} !== e) begin
      miscompares++;
      $display("FAIL reset_state: got t=%0d c=%0b l=%0b exp t=%0d c=%0b l=%0b", bus.thrust, bus.thrust_changed, bus.at_limit, e.t, e.c, e.l);
    end
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) bus.analog_y = 8'h80;
      sb.push_back(k < 2 ? vec_t'{8'd127, k == 0, 1'b0} : vec_t'{8'd254, k == 2, 1'b1});
      @(posedge clk_sys);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({bus.thrust, bus.thrust_changed, bus.at_limit} !== e) begin
        miscompares++;
        $display("FAIL reset_release k=%0d: got t=%0d c=%0b l=%0b exp t=%0d c=%0b l=%0b", k, bus.thrust, bus.thrust_changed, bus.at_limit, e.t, e.c, e.l);
      end
    end
  endtask
  task automatic test_ramp_up();
    int x, prev;
    bus.analog_y = 8'd127;
    sb.push_back('{8'd0, 1'b1, 1'b1});
    @(posedge clk_sys);
    #1;
    e = sb.pop_front();
    vectors++;
    if ({bus.thrust, bus.thrust_changed, bus.at_limit} !== e) begin
      miscompares++;
      $display("FAIL ramp_up_init: got t=%0d c=%0b l=%0b exp t=%0d c=%0b l=%0b", bus.thrust, bus.thrust_changed, bus.at_limit, e.t, e.c, e.l);
    end
    bus.dpad_mode = 1'b1;
    bus.joy_down  = 1'b1;
    prev = 0;
    for (int k = 0; k <= 1040; k++) begin
      x = k == 0 ? 0 : ((k - 1) / 4 > 254 ? 254 : (k - 1) / 4);
      sb.push_back('{8'(x), x != prev, x == 0 || x == 254});
      prev = x;
      @(posedge clk_sys);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({bus.thrust, bus.thrust_changed, bus.at_limit} !== e) begin
        miscompares++;
        $display("FAIL ramp_up k=%0d: got t=%0d c=%0b l=%0b exp t=%0d c=%0b l=%0b", k, bus.thrust, bus.thrust_changed, bus.at_limit, e.t, e.c, e.l);
      end
    end
  endtask
  task automatic test_ramp_down();
    int x, prev;
    bus.dpad_mode = 1'b0;
    bus.joy_down  = 1'b0;
    bus.analog_y  = 8'd124;
    sb.push_back('{8'd3, 1'b1, 1'b0});
    @(posedge clk_sys);
    #1;
    e = sb.pop_front();
    vectors++;
    if ({bus.thrust, bus.thrust_changed, bus.at_limit} !== e) begin
      miscompares++;
      $display("FAIL ramp_down_init: got t=%0d c=%0b l=%0b exp t=%0d c=%0b l=%0b", bus.thrust, bus.thrust_changed, bus.at_limit, e.t, e.c, e.l);
    end
    bus.dpad_mode = 1'b1;
    bus.joy_up    = 1'b1;
    prev = 3;
    for (int k = 0; k <= 40; k++) begin
      x = k == 0 ? 3 : (3 - (k - 1) / 4 < 0 ? 0 : 3 - (k - 1) / 4);
      sb.push_back('{8'(x), x != prev, x == 0 || x == 254});
      prev = x;
      @(posedge clk_sys);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({bus.thrust, bus.thrust_changed, bus.at_limit} !== e) begin
        miscompares++;
        $display("FAIL ramp_down k=%0d: got t=%0d c=%0b l=%0b exp t=%0d c=%0b l=%0b", k, bus.thrust, bus.thrust_changed, bus.at_limit, e.t, e.c, e.l);
      end
    end
  endtask
  task automatic test_both_pressed();
    bus.dpad_mode = 1'b0;
    bus.joy_up    = 1'b0;
    bus.joy_down  = 1'b0;
    bus.analog_y  = 8'd27;
    for (int k = 0; k <= 44; k++) begin
      if (k == 1) begin
        bus.dpad_mode = 1'b1;
        bus.joy_up    = 1'b1;
        bus.joy_down  = 1'b1;
      end
      sb.push_back('{8'd100, k == 0, 1'b0});
      @(posedge clk_sys);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({bus.thrust, bus.thrust_changed, bus.at_limit} !== e) begin
        miscompares++;
        $display("FAIL both_pressed k=%0d: got t=%0d c=%0b l=%0b exp t=%0d c=%0b l=%0b", k, bus.thrust, bus.thrust_changed, bus.at_limit, e.t, e.c, e.l);
      end
    end
  endtask
  task automatic test_bumpless();
    logic [7:0] exp_t [10];
    logic [7:0] prev;
    exp_t = '{8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd65, 8'd65};
    bus.dpad_mode = 1'b0;
    bus.joy_up    = 1'b0;
    bus.joy_down  = 1'b1;
    bus.analog_y  = 8'h3F;
    do_reset();
    prev = 8'd0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) bus.dpad_mode = 1'b1;
      sb.push_back('{exp_t[k], exp_t[k] != prev, 1'b0});
      prev = exp_t[k];
      @(posedge clk_sys);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({bus.thrust, bus.thrust_changed, bus.at_limit} !== e) begin
        miscompares++;
        $display("FAIL bumpless edge=%0d: got t=%0d c=%0b l=%0b exp t=%0d c=%0b l=%0b", k + 1, bus.thrust, bus.thrust_changed, bus.at_limit, e.t, e.c, e.l);
      end
    end
  endtask
  task automatic test_reset_mid_ramp();
    int x, prev;
    bus.dpad_mode = 1'b0;
    bus.joy_down  = 1'b0;
    bus.analog_y  = 8'd29;
    prev = 65;
    for (int k = -1; k <= 9; k++) begin
      if (k == 0) begin
        bus.dpad_mode = 1'b1;
        bus.joy_down  = 1'b1;
      end
      x = k <= 0 ? 98 : 98 + (k - 1) / 4;
      sb.push_back('{8'(x), x != prev, 1'b0});
      prev = x;
      @(posedge clk_sys);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({bus.thrust, bus.thrust_changed, bus.at_limit} !== e) begin
        miscompares++;
        $display("FAIL mid_ramp k=%0d: got t=%0d c=%0b l=%0b exp t=%0d c=%0b l=%0b", k, bus.thrust, bus.thrust_changed, bus.at_limit, e.t, e.c, e.l);
      end
    end
    #2;
    reset = 1'b1;
    sb.push_back('{8'd0, 1'b0, 1'b1});
    #1;
    e = sb.pop_front();
    vectors++;
    if ({bus.thrust, bus.thrust_changed, bus.at_limit} !== e) begin
      miscompares++;
      $display("FAIL async_reset: got t=%0d c=%0b l=%0b exp t=%0d c=%0b l=%0b", bus.thrust, bus.thrust_changed, bus.at_limit, e.t, e.c, e.l);
    end
    bus.dpad_mode = 1'b0;
    bus.joy_down  = 1'b0;
    bus.analog_y  = 8'd127;
    #1;
    reset = 1'b0;
    sb.push_back('{8'd0, 1'b0, 1'b1});
    @(posedge clk_sys);
    #1;
    e = sb.pop_front();
    vectors++;
    if ({bus.thrust, bus.thrust_changed, bus.at_limit} !== e) begin
      miscompares++;
      $display("FAIL post_reset_hold: got t=%0d c=%0b l=%0b exp t=%0d c=%0b l=%0b", bus.thrust, bus.thrust_changed, bus.at_limit, e.t, e.c, e.l);
    end
  endtask
  task automatic test_sweep();
    int x, prev;
    prev = 0;
    for (int v = -128; v <= 127; v++) begin
      bus.analog_y = 8'(v);
      x = 127 - v > 254 ? 254 : 127 - v;
      sb.push_back('{8'(x), x != prev, x == 0 || x == 254});
      prev = x;
      @(posedge clk_sys);
      #1;
      e = sb.pop_front();
      vectors++;
      if ({bus.thrust, bus.thrust_changed, bus.at_limit} !== e) begin
        miscompares++;
        $display("FAIL sweep v=%0d: got t=%0d c=%0b l=%0b exp t=%0d c=%0b l=%0b", v, bus.thrust, bus.thrust_changed, bus.at_limit, e.t, e.c, e.l);
      end
    end
  endtask
  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_both_pressed();
    test_bumpless();
    test_reset_mid_ramp();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
